// File: rtl/gpio_cfg_serializer.sv
// gpio_cfg_serializer: reads each pad's IO configuration word from the
// housekeeping register file and shifts it bit-serially, MSB first, into the
// GPIO control-block chain. The highest pad index is sent first. A single
// load strobe ends the transfer so that every pad latches at the same time.
// Optional build macro GPIO_CFG_SER_ABORT_EN adds an xfer_abort input that
// cancels a transfer during FETCH or SHIFT.
module gpio_cfg_serializer #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned IDX_W    = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                xfer_start,
`ifdef GPIO_CFG_SER_ABORT_EN
  input  logic                xfer_abort,
`endif
  output logic [IDX_W-1:0]    cfg_idx,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PADS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    pad_idx;
  logic [CFG_BITS-1:0] shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic                abort_c;

  // Abort request; tied low when the abort feature is not built in.
`ifdef GPIO_CFG_SER_ABORT_EN
  assign abort_c = xfer_abort;
`else
  assign abort_c = 1'b0;
`endif

  // The pad index register directly addresses the register file; it only
  // changes when moving into FETCH, so it holds its value everywhere else.
  assign cfg_idx = pad_idx;

  // Chain data is the shift register MSB. The register is empty after the
  // last bit of each word, so the line idles low in FETCH, LOAD and IDLE.
  assign serial_data = shreg[CFG_BITS-1];

  // Transfer sequencer: fetch word, shift it out, repeat per pad, then load.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      pad_idx      <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      serial_clock <= 1'b0;
      serial_load  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer_start) begin
            busy    <= 1'b1;
            pad_idx <= IDX_LAST;
            state   <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (abort_c) begin
            state        <= S_IDLE;
            shreg        <= '0;
            div_cnt      <= '0;
            serial_clock <= 1'b0;
            busy         <= 1'b0;
          end else begin
            shreg        <= cfg_data;
            bit_cnt      <= BIT_LAST;
            div_cnt      <= '0;
            serial_clock <= 1'b0;
            state        <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (abort_c) begin
            state        <= S_IDLE;
            shreg        <= '0;
            div_cnt      <= '0;
            serial_clock <= 1'b0;
            busy         <= 1'b0;
          end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!serial_clock) begin
              serial_clock <= 1'b1;
            end else begin
              // End of the high phase: next bit or next word.
              serial_clock <= 1'b0;
              shreg        <= shreg << 1;
              if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - BIT_W'(1);
              end else if (pad_idx != '0) begin
                pad_idx <= pad_idx - IDX_W'(1);
                state   <= S_FETCH;
              end else begin
                serial_load <= 1'b1;
                state       <= S_LOAD;
              end
            end
          end
        end

        S_LOAD: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt     <= '0;
            serial_load <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gpio_cfg_serializer.md
Name: gpio_cfg_serializer

Overview:
- Downstream consumer of the per-pad user-project IO control registers in housekeeping.
- On request, reads each pad's configuration word from the register file and shifts it out bit-serially into the GPIO control-block chain.
- Ends with a load strobe so all pads latch their new configuration at the same time.
- Sits between the housekeeping Wishbone register bank and the pad-side serial chain; runs on the Wishbone clock.

Parameters:
- NUM_PADS, 38, number of pads (chain length in words); must be >= 1.
- CFG_BITS, 13, configuration bits per pad; must be >= 1.
- CLK_DIV, 4, serial_clock half-period in wb_clk_i cycles; must be >= 1.
- IDX_W, 6, width of the pad index; must satisfy 2**IDX_W >= NUM_PADS.

Ports:
- wb_clk_i  in  1  system clock; all state changes on its rising edge.
- wb_rst_i  in  1  reset, asynchronous assert, active-high.
- xfer_start  in  1  single-cycle request to serialize all pads.
- cfg_idx  out  IDX_W  pad index presented to the register file.
- cfg_data  in  CFG_BITS  config word for cfg_idx; combinational read, valid in the same cycle.
- serial_clock  out  1  chain shift clock.
- serial_data  out  1  chain data; MSB first.
- serial_load  out  1  chain latch strobe.
- busy  out  1  high from the start edge until the done cycle inclusive.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous and active-high on wb_rst_i; the single clock is wb_clk_i.
- Reset values: state=IDLE; cfg_idx, serial_clock, serial_data, serial_load, busy and done are all 0; the shift register and all counters are 0.
- States: IDLE, FETCH, SHIFT, LOAD, DONE.
- IDLE:
  - xfer_start=1 at an edge sets busy=1 and pad_idx=NUM_PADS-1, and moves to FETCH.
  - xfer_start is ignored in every other state.
- FETCH (exactly 1 cycle):
  - cfg_idx=pad_idx.
  - At the edge, shreg<=cfg_data, bit_cnt<=CFG_BITS-1, div_cnt<=0, serial_clock<=0; then to SHIFT.
- SHIFT:
  - serial_data=shreg[CFG_BITS-1], held stable for the whole bit.
  - Each bit is CLK_DIV cycles with serial_clock=0, then CLK_DIV cycles with serial_clock=1.
  - At the end of the high phase, serial_clock returns to 0 and shreg shifts left by 1.
  - If bit_cnt!=0: decrement bit_cnt and stay in SHIFT.
  - Else if pad_idx!=0: decrement pad_idx and go to FETCH.
  - Else: go to LOAD.
- Pad order: highest index is sent first, so pad 0's word is last in and sits nearest the chain input.
- LOAD: serial_load=1 for CLK_DIV cycles; serial_clock stays 0; then to DONE.
- DONE: done=1 and busy=1 for 1 cycle; then back to IDLE with busy=0 and serial_load=0.
- cfg_idx holds its last value outside FETCH.
- serial_data returns to 0 on entering LOAD.
- Timing from the start edge to the done cycle inclusive: NUM_PADS*(1+2*CLK_DIV*CFG_BITS) + CLK_DIV + 1 cycles with busy=1.
- Exactly NUM_PADS*CFG_BITS serial_clock rising edges per transfer.
- xfer_start coinciding with the done cycle: ignored. A new transfer is accepted only from IDLE.
- Reset mid-transfer: all outputs go to 0 immediately. No load pulse is issued, and the chain contents are undefined.
- The register file may be written during a transfer. Each pad's word is sampled only in its own FETCH cycle.

Optional Feature:
- Macro: GPIO_CFG_SER_ABORT_EN.
- When defined, adds input port xfer_abort (1 bit). xfer_abort=1 at any edge in FETCH or SHIFT:
  - moves to IDLE next cycle;
  - forces serial_clock=0 and serial_data=0;
  - drops busy, with no serial_load and no done pulse.
- Abort in LOAD or DONE is ignored.
- When undefined: no port, and behaviour is exactly as above.

Test Plan:
- Reset check: assert wb_rst_i asynchronously mid-cycle -> all outputs 0 before the next edge; busy stays 0 with no start.
- Basic transfer with NUM_PADS=2, CFG_BITS=3, CLK_DIV=1, pad1=3'b101, pad0=3'b011, start pulse -> serial_data at the 6 serial_clock rising edges is 1,0,1,0,1,1. Also required:
  - cfg_idx is 1 then 0 in the FETCH cycles;
  - serial_load is high for 1 cycle;
  - done pulses exactly 16 cycles after the start edge, with busy high for those 16 cycles.
- Default parameters, random register contents -> a behavioural 38x13 shift-chain model matches every pad word after the load, with 494 serial_clock rising edges.
- Start during busy, and start in the done cycle -> ignored; exactly one transfer and one done pulse.
- Reset asserted during SHIFT of pad 20 -> serial_load never rises. A subsequent start gives a complete, correct transfer.
- With GPIO_CFG_SER_ABORT_EN: xfer_abort during pad 5 -> busy=0 next cycle, no serial_load, no done. A fresh start completes normally.
